// File: rtl/rr_mux_nx1.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_nx1
// Description : CH-to-1 round-robin multiplexer with a one-entry registered
//               output stage. Define RR_MUX_LOCK_EN for packet-lock
//               arbitration (adds the in_last input).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_nx1 #(
  parameter int N  = 32,
  parameter int CH = 4,
  parameter int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
`ifdef RR_MUX_LOCK_EN
  input  logic [CH-1:0]   in_last,
`endif
  output logic [CH-1:0]   in_ready,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_sel
);

  logic [N-1:0]  w_ch_data [CH];
  logic [SW-1:0] r_ptr;
  logic [N-1:0]  r_data;
  logic          r_valid;
  logic [SW-1:0] r_sel;

  logic          w_load_ok;
  logic          w_rr_vld;
  logic [SW-1:0] w_rr_idx;
  logic [SW:0]   w_sum;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt_idx;
  logic [SW-1:0] w_nxt_ptr;
  logic          w_xfer;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_unpack
      assign w_ch_data[gi] = in_data[gi*N +: N];
    end
  endgenerate

  // Holding register may take a new beat when empty or draining this cycle.
  assign w_load_ok = (!r_valid || out_ready) && !rst;

  // Search ptr, ptr+1, ... modulo CH for the first valid channel.
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    w_sum    = '0;
    for (int k = 0; k < CH; k++) begin
      w_sum = {1'b0, r_ptr} + (SW+1)'(k);
      if (w_sum >= (SW+1)'(CH)) begin
        w_sum = w_sum - (SW+1)'(CH);
      end
      if (!w_rr_vld && in_valid[w_sum[SW-1:0]]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = w_sum[SW-1:0];
      end
    end
  end

`ifdef RR_MUX_LOCK_EN
  logic          r_locked;
  logic [SW-1:0] r_lock_ch;

  always_comb begin
    w_gnt_vld = w_rr_vld;
    w_gnt_idx = w_rr_idx;
    if (r_locked) begin
      w_gnt_vld = in_valid[r_lock_ch];
      w_gnt_idx = r_lock_ch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_xfer) begin
      r_locked  <= !in_last[w_gnt_idx];
      r_lock_ch <= w_gnt_idx;
    end
  end
`else
  always_comb begin
    w_gnt_vld = w_rr_vld;
    w_gnt_idx = w_rr_idx;
  end
`endif

  assign w_xfer    = w_gnt_vld && w_load_ok;
  assign w_nxt_ptr = (w_gnt_idx == SW'(CH - 1)) ? '0 : w_gnt_idx + 1'b1;

  generate
    for (gi = 0; gi < CH; gi++) begin : g_ready
      assign in_ready[gi] = w_xfer && (w_gnt_idx == SW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_xfer) begin
        r_data  <= w_ch_data[w_gnt_idx];
        r_sel   <= w_gnt_idx;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
`ifdef RR_MUX_LOCK_EN
      // Pointer moves only when a packet completes.
      if (w_xfer && in_last[w_gnt_idx]) begin
        r_ptr <= w_nxt_ptr;
      end
`else
      if (w_xfer) begin
        r_ptr <= w_nxt_ptr;
      end
`endif
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: doc/rr_mux_nx1.md
RR_MUX_NX1 -- requirements
Module: rr_mux_nx1

Interface
REQ-001 Parameter N, default 32, data width per channel in bits (N >= 1).
REQ-002 Parameter CH, default 4, number of input channels (CH >= 2).
REQ-003 Parameter SW, default $clog2(CH), select/grant index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  CH*N  packed channel data; channel i occupies bits [i*N +: N].
REQ-007 in_valid  input  CH  per-channel valid.
REQ-008 in_ready  output  CH  per-channel ready; combinational.
REQ-009 out_data  output  N  registered selected data.
REQ-010 out_valid  output  1  registered output valid.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_sel  output  SW  registered index of the channel that produced out_data.

Function
REQ-013 The block SHALL hold a one-entry output register (out_data, out_valid, out_sel) plus a round-robin pointer ptr[SW-1:0].
REQ-014 The register SHALL be loadable ("load_ok") when out_valid==0 or out_ready==1 in the same cycle.
REQ-015 Grant SHALL go to the first channel with in_valid set, searching ptr, ptr+1, ... wrapping modulo CH; no valid channel means no grant.
REQ-016 in_ready[i] SHALL be 1 only for the granted channel and only while load_ok; all other bits 0.
REQ-017 A beat is transferred on channel i when in_valid[i] && in_ready[i]; at that edge out_data <= channel i data, out_sel <= i, out_valid <= 1.
REQ-018 On a transfer from channel i, ptr SHALL become (i+1) mod CH; with no transfer, ptr SHALL hold.
REQ-019 When out_valid && out_ready and no new transfer, out_valid SHALL go to 0; out_data and out_sel hold their values.
REQ-020 Latency SHALL be exactly 1 cycle from input transfer to out_valid; throughput 1 beat/cycle with out_ready held at 1.
REQ-021 While out_valid && !out_ready, out_data/out_sel/out_valid SHALL be stable and all in_ready SHALL be 0.
REQ-022 Simultaneous output drain and input transfer in one cycle SHALL replace the entry with no bubble.
REQ-023 No channel with in_valid held continuously SHALL wait more than CH-1 transfers from other channels (starvation-free).
REQ-024 in_valid deasserted by a source before transfer SHALL cause no state change (no handshake rule enforced on sources).

Reset
REQ-025 While rst is high: out_valid=0, out_data=0, out_sel=0, ptr=0, lock state cleared, in_ready all 0.
REQ-026 Reset asserted mid-transfer SHALL discard the held beat immediately (asynchronous); first grant after release searches from channel 0.

Configuration
REQ-027 Macro RR_MUX_LOCK_EN SHALL select packet-lock arbitration.
REQ-028 With RR_MUX_LOCK_EN defined: additional input in_last[CH-1:0]; after a transfer from channel i with in_last[i]==0 the grant SHALL stay locked to channel i (other in_valid ignored) until a transfer with in_last[i]==1; ptr advances only on that last transfer.
REQ-029 Without RR_MUX_LOCK_EN: port in_last absent, no lock register; every transfer re-arbitrates per REQ-015/018.

Verification
REQ-030 CH=4, N=32, out_ready=1, in_valid=4'b1111 held, data = 0xA0..0xA3 by channel -> out_sel sequence 0,1,2,3,0,... one per cycle, out_data 0xA0,0xA1,0xA2,0xA3.
REQ-031 in_valid=4'b0100 single cycle, out_ready=1 -> out_valid=1 next cycle with out_sel=2, ptr=3; out_valid=0 the cycle after.
REQ-032 Load entry from ch1, hold out_ready=0 for 5 cycles with in_valid=4'b1111 -> outputs stable, in_ready=0 throughout; on out_ready=1 ch2 beat loads same cycle, no bubble.
REQ-033 Streaming from ch0, assert rst mid-stream for 1 cycle -> out_valid drops to 0 asynchronously; after release with in_valid=4'b1010 first grant is ch1.
REQ-034 RR_MUX_LOCK_EN defined, ch0 sends 3 beats (in_last on third), ch3 valid throughout -> out_sel 0,0,0,3; without macro same stimulus -> 0,3,0,3.
REQ-035 Random in_valid/out_ready, 10k cycles -> scoreboard: every transferred beat appears once, in order per channel, no channel waits > 3 foreign transfers.
